entry_control_unit: RTL and testbench
=====================================

ENTRY_CONTROL_UNIT -- requirements
Module: entry_control_unit

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, number of consecutive stable synchronized cycles required before the debounced enter level changes.
REQ-002 Parameter: TIMEOUT_CYCLES, default 16, maximum cycles spent in a WAIT state without inputdata_ready before entering ERROR.
REQ-003 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-low reset.
REQ-005 Port: enter  input  1  asynchronous push-button level from the board.
REQ-006 Port: inputdata_ready  input  1  datapath acknowledge that the requested operand was captured.
REQ-007 Port: loaddata  output  1  one-cycle request to the datapath to capture inputdata.
REQ-008 Port: operand_sel  output  1  operand being requested: 0 = A, 1 = B.
REQ-009 Port: busy  output  1  high in LOAD_A, WAIT_A, ARM_B, LOAD_B, WAIT_B.
REQ-010 Port: done  output  1  high while in DONE.
REQ-011 Port: error  output  1  high while in ERROR.
REQ-012 Port: op_count  output  8  count of completed operand pairs.

Function
REQ-013 enter SHALL pass through a two-flop synchronizer; a third flop holds the previous level; enter_pulse = current & ~previous, one cycle wide.
REQ-014 FSM states SHALL be IDLE, LOAD_A, WAIT_A, ARM_B, LOAD_B, WAIT_B, DONE, ERROR; all outputs Moore-decoded from state/registers.
REQ-015 IDLE: enter_pulse -> LOAD_A; otherwise remain.
REQ-016 LOAD_A: loaddata=1, operand_sel=0, unconditional -> WAIT_A next cycle.
REQ-017 WAIT_A: inputdata_ready=1 -> ARM_B; timeout -> ERROR.
REQ-018 ARM_B: operand_sel=1; enter_pulse -> LOAD_B.
REQ-019 LOAD_B: loaddata=1, operand_sel=1, unconditional -> WAIT_B.
REQ-020 WAIT_B: inputdata_ready=1 -> DONE and op_count increments by 1, wrapping 255 -> 0; timeout -> ERROR.
REQ-021 DONE: enter_pulse -> LOAD_A (new operation, op_count kept).
REQ-022 ERROR: enter_pulse -> IDLE; op_count unchanged.
REQ-023 Timeout counter SHALL clear on entry to each WAIT state and increment every WAIT cycle; timeout when it reaches TIMEOUT_CYCLES.
REQ-024 inputdata_ready and timeout in the same cycle: ready wins.
REQ-025 inputdata_ready outside WAIT_A/WAIT_B SHALL be ignored.
REQ-026 enter_pulse in LOAD_x/WAIT_x SHALL be discarded, never queued.
REQ-027 loaddata SHALL be high for exactly one cycle per operand; operand_sel valid in that same cycle.
REQ-028 Latency without debounce: with enter first sampled high at edge k, loaddata SHALL be high in the cycle following edge k+3.

Reset
REQ-029 While reset=0 at a rising edge: state=IDLE, timeout counter=0, op_count=0, loaddata=operand_sel=busy=done=error=0.
REQ-030 Synchronizer, previous-level and debounced-level flops SHALL reset to 1, so enter held high across reset release produces no pulse.
REQ-031 Reset mid-operation (any state) SHALL abort to IDLE on the next edge; no further loaddata issued.

Configuration
REQ-032 Macro ENTER_DEBOUNCE_EN defined: synchronized enter SHALL be stable for DEBOUNCE_CYCLES consecutive cycles before the debounced level updates; edge detect uses the debounced level; latency of REQ-028 grows by DEBOUNCE_CYCLES.
REQ-033 Macro ENTER_DEBOUNCE_EN undefined: no debounce logic; edge detect on synchronizer output; DEBOUNCE_CYCLES unused.

Verification
REQ-034 Reset, press enter, ready=1 two cycles after each loaddata, press enter again -> loaddata pulses with operand_sel 0 then 1, done=1, op_count=1.
REQ-035 Press enter, hold inputdata_ready=0 -> error=1 exactly 16 WAIT_A cycles later; press enter -> IDLE, op_count unchanged.
REQ-036 Ready asserted in the 16th WAIT cycle -> DONE/ARM_B path taken, error stays 0.
REQ-037 Enter pulses during WAIT_A and 256 full operations -> extra presses ignored, op_count wraps to 0.
REQ-038 Debounce build, enter glitch high for 3 cycles -> no loaddata; held 10 cycles -> one loaddata; reset asserted in WAIT_B with enter held high -> IDLE, all outputs 0, no pulse after release.

Source files
------------

// File: rtl/entry_control_unit.sv
// entry_control_unit: sequences the capture of two operands (A then B) from
// a push-button "enter" input, with a per-WAIT timeout and a pair counter.
// Optional build macro: ENTER_DEBOUNCE_EN adds a DEBOUNCE_CYCLES stability
// filter between the synchronizer and the edge detector.
module entry_control_unit #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter,
  input  logic       inputdata_ready,
  output logic       loaddata,
  output logic       operand_sel,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] op_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_A, WAIT_A, ARM_B, LOAD_B, WAIT_B, DONE, ERROR
  } state_e;

  // Reject parameter values that make the counters meaningless.
  if (DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("entry_control_unit: DEBOUNCE_CYCLES>=1 and TIMEOUT_CYCLES>=2 required");
  end

  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [7:0]    cnt_q, cnt_d;

  logic sync1_q, sync2_q, prev_q, pulse_q;
  logic lvl;        // level seen by the edge detector
  logic timeout;

`ifdef ENTER_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  logic          deb_q;
  logic [DW-1:0] dcnt_q;

  // Debounce: the level only follows the synchronizer after it has disagreed
  // for DEBOUNCE_CYCLES consecutive samples; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      deb_q  <= 1'b1;
      dcnt_q <= '0;
    end else if (sync2_q == deb_q) begin
      dcnt_q <= '0;
    end else if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
      deb_q  <= sync2_q;
      dcnt_q <= '0;
    end else begin
      dcnt_q <= dcnt_q + 1'b1;
    end
  end

  assign lvl = deb_q;
`else
  assign lvl = sync2_q;
`endif

  // Synchronizer, previous-level flop and registered rising-edge pulse. The
  // level flops reset high so a button held through reset release is not a press.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= enter;
      sync2_q <= sync1_q;
      prev_q  <= lvl;
      pulse_q <= lvl & ~prev_q;
    end
  end

  // The timer reads TIMEOUT_CYCLES-1 in the last allowed WAIT cycle.
  assign timeout = (tmr_q == TW'(TIMEOUT_CYCLES - 1));

  // State, timeout counter and pair counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; presses outside IDLE/ARM_B/DONE/ERROR are dropped, and
  // ready beats timeout when both land in the same WAIT cycle.
  always_comb begin
    state_d = state_q;
    tmr_d   = '0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:   if (pulse_q) state_d = LOAD_A;
      LOAD_A: state_d = WAIT_A;
      WAIT_A: begin
        tmr_d = tmr_q + 1'b1;
        if (inputdata_ready) state_d = ARM_B;
        else if (timeout)    state_d = ERROR;
      end
      ARM_B:  if (pulse_q) state_d = LOAD_B;
      LOAD_B: state_d = WAIT_B;
      WAIT_B: begin
        tmr_d = tmr_q + 1'b1;
        if (inputdata_ready) begin
          state_d = DONE;
          cnt_d   = cnt_q + 8'd1;
        end else if (timeout) begin
          state_d = ERROR;
        end
      end
      DONE:   if (pulse_q) state_d = LOAD_A;
      ERROR:  if (pulse_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign loaddata    = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign operand_sel = (state_q == ARM_B) || (state_q == LOAD_B) || (state_q == WAIT_B);
  assign busy        = (state_q == LOAD_A) || (state_q == WAIT_A) || (state_q == ARM_B) ||
                       (state_q == LOAD_B) || (state_q == WAIT_B);
  assign done        = (state_q == DONE);
  assign error       = (state_q == ERROR);
  assign op_count    = cnt_q;

endmodule

// File: tb/tb_entry_control_unit.sv
module tb_entry_control_unit;
`ifdef ENTER_DEBOUNCE_EN
  localparam int DB = 4;
`else
  localparam int DB = 0;
`endif

  logic       clk = 1'b0;
  logic       reset, enter, inputdata_ready;
  logic       loaddata, operand_sel, busy, done, error;
  logic [7:0] op_count;

  int checks = 0;
  int failures = 0;
  bit exp_sel_q[$];
  logic [7:0] exp_cnt = 8'd0;

  entry_control_unit #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .enter(enter), .inputdata_ready(inputdata_ready),
    .loaddata(loaddata), .operand_sel(operand_sel), .busy(busy), .done(done),
    .error(error), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic watch(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin step(1); if (loaddata) cnt++; end
  endtask

  // Press enter and wait (bounded) for the resulting loaddata cycle; the
  // expected operand is queued at the press and popped when loaddata shows.
  task automatic press_load(input bit sel, input bit hold);
    bit found = 0;
    bit e;
    exp_sel_q.push_back(sel);
    enter = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1);
      if (loaddata) found = 1;
    end
    chk("load_seen", 32'(found), 32'd1);
    e = exp_sel_q.pop_front();
    if (found) chk("load_sel", 32'(operand_sel), 32'(e));
    if (!hold) enter = 1'b0;
  endtask

  // Ready two cycles after the loaddata cycle.
  task automatic ready_after();
    step(2);
    inputdata_ready = 1'b1;
    step(1);
    inputdata_ready = 1'b0;
  endtask

  task automatic full_op();
    press_load(1'b0, 1'b0);
    ready_after();
    chk("op_armb", 32'({operand_sel, busy, loaddata}), 32'b110);
    step(DB + 4);
    press_load(1'b1, 1'b0);
    ready_after();
    exp_cnt = exp_cnt + 8'd1;
    chk("op_done", 32'({done, busy}), 32'b10);
    chk("op_count", 32'(op_count), 32'(exp_cnt));
    step(DB + 4);
  endtask

  initial begin
    int c0, c1;
    bit seen;
    reset = 1'b0; enter = 1'b0; inputdata_ready = 1'b0;
    step(3);
    chk("reset_outs", 32'({loaddata, operand_sel, busy, done, error}), 32'd0);
    chk("reset_cnt", 32'(op_count), 32'd0);
    reset = 1'b1;
    step(DB + 6);
    chk("idle_quiet", 32'({loaddata, busy}), 32'd0);

    // Press-to-loaddata latency: 3 edges after first sample (+DB with debounce).
    exp_sel_q.push_back(1'b0);
    enter = 1'b1;
    step(3 + DB);
    chk("lat_early", 32'(loaddata), 32'd0);
    step(1);
    chk("lat_load", 32'(loaddata), 32'd1);
    chk("lat_sel", 32'(operand_sel), 32'(exp_sel_q.pop_front()));
    enter = 1'b0;
    step(1);
    chk("load_one_cycle", 32'({loaddata, busy}), 32'b01);
    step(1);
    inputdata_ready = 1'b1;
    step(1);
    inputdata_ready = 1'b0;
    chk("arm_b", 32'({operand_sel, busy, loaddata}), 32'b110);
    step(DB + 4);
    press_load(1'b1, 1'b0);
    ready_after();
    exp_cnt = 8'd1;
    chk("first_done", 32'({done, error, busy}), 32'b100);
    chk("first_count", 32'(op_count), 32'(exp_cnt));

    // Ready outside WAIT is ignored.
    inputdata_ready = 1'b1;
    step(3);
    inputdata_ready = 1'b0;
    chk("ready_ignored", 32'({done, op_count}), 32'({1'b1, exp_cnt}));
    step(DB + 4);

    // Timeout: error after exactly 16 WAIT_A cycles.
    press_load(1'b0, 1'b0);
    step(16);
    chk("tmo_before", 32'({error, busy}), 32'b01);
    step(1);
    chk("tmo_error", 32'({error, busy}), 32'b10);
    enter = 1'b1;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1);
      if (!error) seen = 1;
    end
    chk("err_exit", 32'(seen), 32'd1);
    chk("err_idle", 32'({busy, done, loaddata}), 32'd0);
    chk("err_count", 32'(op_count), 32'(exp_cnt));
    enter = 1'b0;
    step(DB + 4);

    // Extra press during WAIT_A is dropped; ready in the 16th cycle wins.
    press_load(1'b0, 1'b0);
    watch(DB + 3, c0);
    enter = 1'b1;
    watch(DB + 4, c1);
    c0 += c1;
    enter = 1'b0;
    watch(16 - (2 * DB + 7), c1);
    c0 += c1;
    inputdata_ready = 1'b1;
    step(1);
    inputdata_ready = 1'b0;
    chk("rdy16_a", 32'({error, operand_sel, busy}), 32'b011);
    watch(DB + 5, c1);
    chk("wait_press_dropped", 32'(c0 + c1), 32'd0);
    press_load(1'b1, 1'b0);
    step(16);
    inputdata_ready = 1'b1;
    step(1);
    inputdata_ready = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    chk("rdy16_b", 32'({done, error}), 32'b10);
    chk("rdy16_count", 32'(op_count), 32'(exp_cnt));
    step(DB + 4);

    // Run until the pair counter wraps back to zero.
    repeat (254) full_op();
    chk("wrap_zero", 32'(op_count), 32'd0);

    // Reset in WAIT_B with enter held: abort, then no press after release.
    press_load(1'b0, 1'b0);
    ready_after();
    step(DB + 4);
    press_load(1'b1, 1'b1);
    step(2);
    chk("in_wait_b", 32'({busy, operand_sel}), 32'b11);
    reset = 1'b0;
    step(1);
    chk("midrst_outs", 32'({loaddata, operand_sel, busy, done, error}), 32'd0);
    chk("midrst_cnt", 32'(op_count), 32'd0);
    step(2);
    reset = 1'b1;
    watch(DB + 12, c0);
    chk("no_pulse_release", 32'({c0[7:0], busy}), 32'd0);
    enter = 1'b0;
    step(DB + 4);

`ifdef ENTER_DEBOUNCE_EN
    // Short glitch is filtered; a long hold gives exactly one load.
    enter = 1'b1;
    step(3);
    enter = 1'b0;
    watch(DB + 10, c0);
    chk("glitch_filtered", 32'(c0), 32'd0);
    enter = 1'b1;
    watch(10, c0);
    enter = 1'b0;
    watch(10, c1);
    chk("hold_one_load", 32'(c0 + c1), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
